ps2_rx_frame: RTL and testbench

PS/2 device-to-host frame receiver. It sits directly upstream of the scancode FIFO/decoder inside top_ps2_pcm.
- Synchronises and deglitches the open-collector ps2_clk/ps2_dat lines.
- Deserialises 11-bit frames: start 0, 8 data bits LSB-first, odd parity, stop 1.
- Presents each good byte on a valid/ready interface and reports framing errors.
- Receive only; the block never drives the PS/2 lines.

---
 rtl/ps2_rx_frame.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host frame receiver. It conditions the asynchronous
// open-collector ps2_clk/ps2_dat pins, deserialises 11-bit frames (start 0,
// 8 data bits LSB first, odd parity, stop 1) and hands each good byte to a
// valid/ready consumer. Framing problems, inter-edge timeouts and consumer
// overruns are reported as a one-cycle strobe plus a sticky code. The block
// only listens and never drives the PS/2 lines.
//
// Ports
//   clk        in   system clock, everything on its rising edge
//   rst        in   synchronous active-low reset
//   ps2_clk    in   PS/2 clock pin (asynchronous, idle high)
//   ps2_dat    in   PS/2 data pin (asynchronous, idle high)
//   rx_data    out  received byte, stable while rx_valid is high
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accept (transfer on rx_valid & rx_ready)
//   err_pulse  out  one-cycle strobe on any error
//   err_code   out  last error: 1 start, 2 parity, 3 stop, 4 timeout,
//                   5 overrun; held until the next error
//   busy       out  high while a frame is being received
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int TIMEOUT_CYCLES = SYS_CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      FILT_MAX = 8'(FILTER_LEN - 1);

  localparam logic [2:0] ERR_START   = 3'd1;
  localparam logic [2:0] ERR_PARITY  = 3'd2;
  localparam logic [2:0] ERR_STOP    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic            clk_meta_r, clk_sync_r;
  logic            dat_meta_r, dat_sync_r;
  logic            clk_filt_r, clk_filt_d_r;
  logic [7:0]      filt_cnt_r;
  logic            fall_s;

  state_t          state_r, state_n;
  logic [2:0]      bit_cnt_r, bit_cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic            par_r, par_n;
  logic [TO_W-1:0] to_cnt_r, to_cnt_n;

  logic            good_s;
  logic            frame_err_s;
  logic [2:0]      frame_code_s;
  logic            overrun_s;

  // Two-flop synchronisers on both pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Clock deglitcher: the filtered clock follows only after FILTER_LEN
  // consecutive samples of the new level; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
      filt_cnt_r   <= 8'd0;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r == clk_filt_r) begin
        filt_cnt_r <= 8'd0;
      end else if (filt_cnt_r == FILT_MAX) begin
        clk_filt_r <= clk_sync_r;
        filt_cnt_r <= 8'd0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 8'd1;
      end
    end
  end

  assign fall_s = clk_filt_d_r & ~clk_filt_r;

  // Frame FSM state, shifter and inter-edge timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      to_cnt_r  <= to_cnt_n;
    end
  end

  // Next-state logic: advances on filtered falls; timeout is the only
  // transition that happens between falls.
  always_comb begin
    state_n      = state_r;
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    par_n        = par_r;
    good_s       = 1'b0;
    frame_err_s  = 1'b0;
    frame_code_s = 3'd0;

    if ((state_r == S_IDLE) || fall_s) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt_r + TO_W'(1);
    end

    if (fall_s) begin
      case (state_r)
        S_IDLE: begin
          if (!dat_sync_r) begin
            state_n   = S_DATA;
            bit_cnt_n = 3'd0;
            shift_n   = 8'd0;
          end else begin
            frame_err_s  = 1'b1;
            frame_code_s = ERR_START;
          end
        end
        S_DATA: begin
          shift_n = {dat_sync_r, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_n   = S_PARITY;
            bit_cnt_n = 3'd0;
          end else begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end
        S_PARITY: begin
          par_n   = dat_sync_r;
          state_n = S_STOP;
        end
        S_STOP: begin
          // A bad stop bit outranks a parity fault.
          if (!dat_sync_r) begin
            frame_err_s  = 1'b1;
            frame_code_s = ERR_STOP;
          end else if (!parity_ok(shift_r, par_r)) begin
            frame_err_s  = 1'b1;
            frame_code_s = ERR_PARITY;
          end else begin
            good_s = 1'b1;
          end
          state_n   = S_IDLE;
          bit_cnt_n = 3'd0;
        end
        default: begin
          state_n   = S_IDLE;
          bit_cnt_n = 3'd0;
        end
      endcase
    end else if ((state_r != S_IDLE) && (to_cnt_r == TO_MAX)) begin
      frame_err_s  = 1'b1;
      frame_code_s = ERR_TIMEOUT;
      state_n      = S_IDLE;
      bit_cnt_n    = 3'd0;
      shift_n      = 8'd0;
      to_cnt_n     = '0;
    end else begin
      state_n = state_r;
    end
  end

  // A good byte arriving while an unaccepted byte is still held is dropped.
  assign overrun_s = good_s & rx_valid & ~rx_ready;

  // Registered output stage: byte handshake, error strobe/code and busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 3'd0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_n != S_IDLE);

      // Accept and load in the same cycle keeps rx_valid high with the new byte.
      if (good_s && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end

      if (frame_err_s) begin
        err_pulse <= 1'b1;
        err_code  <= frame_code_s;
      end else if (overrun_s) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_OVERRUN;
      end else begin
        err_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_rx_frame. Frames are built as bit vectors,
// the expected outcome of each frame (byte or error code) is queued by a
// frame-level model, and a monitor matches DUT transfers/errors in order.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err_pulse;
  logic [2:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  ps2_rx_frame #(
    .SYS_CLK_HZ(100_000_000),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  logic [2:0] exp_errs[$];
  logic [2:0] model_code = 3'd0;
  bit         held = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Frame bits, index 0 first on the wire: start, data LSB first, parity, stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {~bad_stop, par, d, 1'b0};
  endfunction

  // Frame-level model: what the receiver must report for one whole frame.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    if (bad_stop) exp_errs.push_back(3'd3);
    else if (bad_par) exp_errs.push_back(3'd2);
    else if (rx_ready) exp_bytes.push_back(d);
    else if (!held) begin
      exp_bytes.push_back(d);
      held = 1'b1;
    end else exp_errs.push_back(3'd5);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk);
    #1;
    rx_ready = v;
    if (v) held = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_code", err_code, 3'd0);
    check("rst_busy", busy, 1'b0);
    exp_bytes.delete();
    exp_errs.delete();
    model_code = 3'd0;
    held = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Monitor: every transfer and every error strobe must match the model queues.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (err_pulse) begin
        check("err_single_cycle", prev_err, 1'b0);
        if (exp_errs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected: got code %0d, expected no error", err_code);
        end else begin
          model_code = exp_errs.pop_front();
          check("err_code", err_code, model_code);
        end
      end else begin
        check("err_code_hold", err_code, model_code);
      end
      if (rx_valid && rx_ready) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected: got 0x%0h, expected no transfer", rx_data);
        end else begin
          check("rx_byte", rx_data, exp_bytes.pop_front());
        end
      end
      if (rx_valid && prev_valid && !prev_ready) check("rx_data_stable", rx_data, prev_data);
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_err   = err_pulse;
      prev_data  = rx_data;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_err   = 1'b0;
      prev_data  = 8'h00;
    end
  end

  initial begin
    logic [10:0] fr;
    bit          found;
    int          cnt;
    bit          busy_seen;

    do_reset(2);

    // Good 0x1C at a 6 us bit period; latency from the stop-bit pin fall.
    set_ready(1'b1);
    model_frame(8'h1C, 1'b0, 1'b0);
    fr = mk_frame(8'h1C, 1'b0, 1'b0);
    send_bits(fr, 10, 300);
    ps2_dat = 1'b1;
    tick(300);
    ps2_clk = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= FILTER_LEN + 4; k++) begin
      @(negedge clk);
      if (!found && rx_valid) begin
        found = 1'b1;
        check("lat_rx_data", rx_data, 8'h1C);
      end
    end
    check("lat_valid_in_time", found, 1'b1);
    tick(300);
    ps2_clk = 1'b1;
    tick(20);
    check("good_busy_idle", busy, 1'b0);
    check("good_no_err", err_code, 3'd0);

    // Parity error, then stop error.
    model_frame(8'h1C, 1'b1, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11, 40);
    tick(20);
    check("parity_code", err_code, 3'd2);
    model_frame(8'hF0, 1'b0, 1'b1);
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11, 40);
    tick(20);
    check("stop_code", err_code, 3'd3);

    // Timeout after start + 4 data bits, then a good 0x29.
    exp_errs.push_back(3'd4);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5, 40);
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 25000) begin
      @(negedge clk);
      cnt++;
      if (err_pulse) found = 1'b1;
    end
    check("timeout_seen", found, 1'b1);
    check("timeout_window", ((cnt + 40 >= TIMEOUT_CYCLES) && (cnt + 40 <= TIMEOUT_CYCLES + FILTER_LEN + 8)), 1'b1);
    check("timeout_code", err_code, 3'd4);
    tick(5);
    check("timeout_busy", busy, 1'b0);
    tick(4000);
    model_frame(8'h29, 1'b0, 1'b0);
    send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11, 40);
    tick(20);

    // Overrun with the consumer stalled.
    set_ready(1'b0);
    model_frame(8'h1C, 1'b0, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11, 40);
    tick(20);
    model_frame(8'h32, 1'b0, 1'b0);
    send_bits(mk_frame(8'h32, 1'b0, 1'b0), 11, 40);
    tick(20);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h1C);
    check("ovr_code", err_code, 3'd5);
    set_ready(1'b1);
    tick(5);
    check("ovr_drained", rx_valid, 1'b0);

    // Short clock glitches while idle must be ignored.
    busy_seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      for (int c = 0; c < 20; c++) begin
        tick(1);
        if (busy) busy_seen = 1'b1;
      end
    end
    check("glitch_busy", busy_seen, 1'b0);
    check("glitch_code", err_code, 3'd5);

    // Data high at a fall while idle is a start error.
    exp_errs.push_back(3'd1);
    ps2_dat = 1'b1;
    tick(40);
    ps2_clk = 1'b0;
    tick(40);
    ps2_clk = 1'b1;
    tick(20);
    check("start_code", err_code, 3'd1);
    check("start_busy", busy, 1'b0);

    // Reset mid-frame, then a clean 0xAA.
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 5, 40);
    do_reset(2);
    set_ready(1'b1);
    model_frame(8'hAA, 1'b0, 1'b0);
    send_bits(mk_frame(8'hAA, 1'b0, 1'b0), 11, 40);
    tick(20);
    check("rst_frame_drained", exp_bytes.size(), 0);

    // Randomised frames, error modes, consumer stalls and sub-filter glitches.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int         mode;
      int         half;
      if ($urandom_range(0, 99) < 35) set_ready($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 25) begin
        ps2_clk = 1'b0;
        tick($urandom_range(1, FILTER_LEN - 2));
        ps2_clk = 1'b1;
        tick(20);
      end
      d    = 8'($urandom());
      mode = $urandom_range(0, 99);
      half = $urandom_range(20, 60);
      model_frame(d, (mode >= 70 && mode < 85), (mode >= 85));
      send_bits(mk_frame(d, (mode >= 70 && mode < 85), (mode >= 85)), 11, half);
      tick(20);
    end

    set_ready(1'b1);
    tick(50);
    check("end_bytes_drained", exp_bytes.size(), 0);
    check("end_errs_drained", exp_errs.size(), 0);
    check("end_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
